// File: rtl/bist_pattern_gen.sv
// BIST pattern generator: ring, Johnson or Galois-LFSR sequences on the LED bank,
// stepped by a programmable divider or by single-step, with wrap and step counting.
module bist_pattern_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DIV_W     = 24,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic [DIV_W-1:0] step_div,
  input  logic             single_step,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  output logic [WIDTH-1:0] led,
  output logic             step_tick,
  output logic             wrap,
  output logic [15:0]      step_count
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_LFSR    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RING_HI = ONE << (WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] ring_q, ring_d;
  logic [WIDTH-1:0] johnson_q, johnson_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lfsr_start_q, lfsr_start_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             step;
  logic             wrap_hit;
  logic [WIDTH-1:0] seed_nz;

  assign seed_nz = (seed == '0) ? ONE : seed;

  always_comb begin
    mode_d       = mode_q;
    ring_d       = ring_q;
    johnson_d    = johnson_q;
    lfsr_d       = lfsr_q;
    lfsr_start_d = lfsr_start_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    wrap_d       = 1'b0;
    step         = 1'b0;
    wrap_hit     = 1'b0;
    led_d        = '0;

    if (mode_e'(mode) != mode_q) begin
      mode_d = mode_e'(mode);
      div_d  = '0;
      cnt_d  = '0;
    end else if (mode_q == MODE_OFF) begin
      div_d = '0;
    end else if (seed_load) begin
      div_d = '0;
      cnt_d = '0;
      case (mode_q)
        MODE_RING:    ring_d = seed_nz;
        MODE_JOHNSON: johnson_d = seed;
        MODE_LFSR: begin
          lfsr_d       = seed_nz;
          lfsr_start_d = seed_nz;
        end
        default: ;
      endcase
    end else begin
      if (run) begin
        if (div_q == step_div) begin
          step  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end else begin
        div_d = '0;
        step  = single_step;
      end

      if (step) begin
        case (mode_q)
          MODE_RING: begin
            ring_d   = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
            wrap_hit = (ring_q == RING_HI);
          end
          MODE_JOHNSON: begin
            johnson_d = {johnson_q[WIDTH-2:0], ~johnson_q[WIDTH-1]};
            wrap_hit  = (johnson_d == '0);
          end
          MODE_LFSR: begin
            lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
            wrap_hit = (lfsr_d == lfsr_start_q);
          end
          default: ;
        endcase
        tick_d = 1'b1;
        wrap_d = wrap_hit;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end

    // led follows the post-edge generator state so it moves on the stepping edge itself
    case (mode_d)
      MODE_RING:    led_d = ring_d;
      MODE_JOHNSON: led_d = johnson_d;
      MODE_LFSR:    led_d = lfsr_d;
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_OFF;
      ring_q       <= ONE;
      johnson_q    <= '0;
      lfsr_q       <= ONE;
      lfsr_start_q <= ONE;
      div_q        <= '0;
      led_q        <= '0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mode_q       <= mode_d;
      ring_q       <= ring_d;
      johnson_q    <= johnson_d;
      lfsr_q       <= lfsr_d;
      lfsr_start_q <= lfsr_start_d;
      div_q        <= div_d;
      led_q        <= led_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
      cnt_q        <= cnt_d;
    end
  end

  assign led        = led_q;
  assign step_tick  = tick_q;
  assign wrap       = wrap_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed bench for bist_pattern_gen at WIDTH=8, LFSR taps 8'hB8.
module tb_bist_pattern_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        run;
  logic [23:0] step_div;
  logic        single_step;
  logic [7:0]  seed;
  logic        seed_load;
  logic [7:0]  led;
  logic        step_tick;
  logic        wrap;
  logic [15:0] step_count;

  int nvec = 0;
  int nmis = 0;

  bist_pattern_gen #(
    .WIDTH(8),
    .DIV_W(24),
    .LFSR_TAPS(8'hB8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .run(run),
    .step_div(step_div),
    .single_step(single_step),
    .seed(seed),
    .seed_load(seed_load),
    .led(led),
    .step_tick(step_tick),
    .wrap(wrap),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        run;
    logic [23:0] div;
    logic        ss;
    logic [7:0]  seed;
    logic        sl;
    logic [7:0]  e_led;
    logic        e_tick;
    logic        e_wrap;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic [1:0] m, logic rn, logic [23:0] d, logic s,
                               logic [7:0] sd, logic l, logic [7:0] el, logic et, logic ew,
                               logic [15:0] ec);
    vec_t v;
    v.rst = r; v.mode = m; v.run = rn; v.div = d; v.ss = s; v.seed = sd; v.sl = l;
    v.e_led = el; v.e_tick = et; v.e_wrap = ew; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic [7:0] lfsr_nx(logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic drive(logic r, logic [1:0] m, logic rn, logic [23:0] d, logic s,
                       logic [7:0] sd, logic l);
    rst = r; mode = m; run = rn; step_div = d; single_step = s; seed = sd; seed_load = l;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] el, logic et, logic ew, logic [15:0] ec);
    nvec++;
    if (led !== el || step_tick !== et || wrap !== ew || step_count !== ec) begin
      nmis++;
      $display("FAIL %s: got led=%h tick=%b wrap=%b cnt=%0d, want led=%h tick=%b wrap=%b cnt=%0d",
               name, led, step_tick, wrap, step_count, el, et, ew, ec);
    end
  endtask

  task automatic check_val(string name, logic [15:0] got, logic [15:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    logic [7:0] jexp [16];
    logic [7:0] exp_led;
    logic       seen_zero;
    int         wrap_at;

    drive(1, 2'd0, 0, 24'd0, 0, 8'h00, 0);

    // reset
    tbl.push_back(mkv(1, 2'd0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(1, 2'd1, 1, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0));
    // ring free-run, step every cycle
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h02, 1, 0, 1));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h04, 1, 0, 2));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h08, 1, 0, 3));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h10, 1, 0, 4));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h20, 1, 0, 5));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h40, 1, 0, 6));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h80, 1, 0, 7));
    tbl.push_back(mkv(0, 2'd1, 1, 0, 0, 8'h00, 0, 8'h01, 1, 1, 8));
    // single-step pulses
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 8));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h02, 1, 0, 9));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h02, 0, 0, 9));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h04, 1, 0, 10));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h04, 0, 0, 10));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h08, 1, 0, 11));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h08, 0, 0, 11));
    // single_step held five cycles
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h10, 1, 0, 12));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h20, 1, 0, 13));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h40, 1, 0, 14));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h80, 1, 0, 15));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h01, 1, 1, 16));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 16));
    // run=1 with single_step=1: divider rate only (step_div=2)
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h01, 0, 0, 16));
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h01, 0, 0, 16));
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h02, 1, 0, 17));
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h02, 0, 0, 17));
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h02, 0, 0, 17));
    tbl.push_back(mkv(0, 2'd1, 1, 2, 1, 8'h00, 0, 8'h04, 1, 0, 18));
    tbl.push_back(mkv(0, 2'd1, 0, 2, 1, 8'h00, 0, 8'h08, 1, 0, 19));
    tbl.push_back(mkv(0, 2'd1, 0, 2, 0, 8'h00, 0, 8'h08, 0, 0, 19));
    // mode away and back: generator state retained
    tbl.push_back(mkv(0, 2'd2, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h08, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h10, 1, 0, 1));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h20, 1, 0, 2));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h20, 0, 0, 2));
    // ring seed loads: zero maps to 1
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h81, 1, 8'h81, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h03, 1, 0, 1));
    // off mode: led 0, seed_load and steps ignored
    tbl.push_back(mkv(0, 2'd0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd0, 1, 0, 1, 8'hFF, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h03, 0, 0, 0));
    // seed_load beats step
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h40, 1, 8'h40, 0, 0, 0));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h80, 1, 0, 1));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 1, 8'h00, 0, 8'h01, 1, 1, 2));
    tbl.push_back(mkv(0, 2'd1, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 2));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].run, tbl[i].div, tbl[i].ss, tbl[i].seed, tbl[i].sl);
      cyc();
      check($sformatf("vec%0d", i), tbl[i].e_led, tbl[i].e_tick, tbl[i].e_wrap, tbl[i].e_cnt);
    end

    // Johnson at step_div=3: one step every 4 cycles, wrap on 16th step
    jexp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
             8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    drive(0, 2'd2, 1, 24'd3, 0, 8'h00, 0);
    cyc();
    check("john_sel", 8'h00, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        check($sformatf("john_idle%0d_%0d", k, j), (k == 0) ? 8'h00 : jexp[k-1], 0, 0, 16'(k));
      end
      cyc();
      check($sformatf("john_step%0d", k + 1), jexp[k], 1, (k == 15), 16'(k + 1));
    end

    // LFSR: seed 0 loads 1, full period 255
    drive(0, 2'd3, 1, 24'd0, 0, 8'h00, 0);
    cyc();
    check("lfsr_sel", 8'h01, 0, 0, 0);
    drive(0, 2'd3, 1, 24'd0, 0, 8'h00, 1);
    cyc();
    check("lfsr_seed0", 8'h01, 0, 0, 0);
    seed_load = 0;
    exp_led = 8'h01;
    seen_zero = 0;
    for (int s = 1; s <= 255; s++) begin
      cyc();
      exp_led = lfsr_nx(exp_led);
      if (led == 8'h00) seen_zero = 1;
      check($sformatf("lfsr1_s%0d", s), exp_led, 1, (s == 255), 16'(s));
    end
    check_val("lfsr_return_01", {8'h00, led}, 16'h0001);
    check_val("lfsr_no_zero", {15'd0, seen_zero}, 16'h0000);

    // LFSR seeded with 5A: wrap on return to 5A
    drive(0, 2'd3, 1, 24'd0, 0, 8'h5A, 1);
    cyc();
    check("lfsr_seed5a", 8'h5A, 0, 0, 0);
    seed_load = 0;
    exp_led = 8'h5A;
    wrap_at = 0;
    for (int s = 1; s <= 260 && wrap_at == 0; s++) begin
      cyc();
      exp_led = lfsr_nx(exp_led);
      if (wrap) wrap_at = s;
      check($sformatf("lfsr2_s%0d", s), exp_led, 1, (s == 255), 16'(s));
    end
    check_val("lfsr2_wrap_step", 16'(wrap_at), 16'd255);
    check_val("lfsr2_wrap_led", {8'h00, led}, 16'h005A);

    // reset pulse mid-run in LFSR mode
    repeat (3) cyc();
    rst = 1;
    cyc();
    check("rst_mid", 8'h00, 0, 0, 0);
    rst = 0;
    cyc();
    check("rst_resel", 8'h01, 0, 0, 0);
    cyc();
    check("rst_step1", 8'hB8, 1, 0, 1);
    cyc();
    check("rst_step2", 8'h5C, 1, 0, 2);

    // step_count saturation
    drive(0, 2'd1, 1, 24'd0, 0, 8'h00, 0);
    cyc();
    check_val("sat_start", step_count, 16'h0000);
    repeat (65540) cyc();
    check_val("sat_count", step_count, 16'hFFFF);
    check_val("sat_tick", {15'd0, step_tick}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bist_pattern_gen.md
Name: bist_pattern_gen

Overview:
Parametrised BIST pattern generator that drives the LED bank with ring, Johnson or LFSR sequences of configurable width. It is the successor to the fixed 16-bit BIST datapath. It replaces per-counter gated clocks with a single clock plus a programmable step divider. It adds single-step, seed loading, wrap detection and a step counter, and sits between the BIST controller FSM and the board LED pins.

Parameters:
WIDTH, 16, pattern/LED width; legal range 4..32.
DIV_W, 24, width of step divider count and step_div port.
LFSR_TAPS, 16'hB400, Galois feedback mask (WIDTH bits); must describe a maximal-length polynomial.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
mode  input  2  00 off, 01 ring, 10 Johnson, 11 LFSR.
run  input  1  1 = free-run stepping at divider rate.
step_div  input  DIV_W  step period minus one, in clk cycles.
single_step  input  1  when run=0, one step per cycle it is high.
seed  input  WIDTH  seed value for the selected generator.
seed_load  input  1  load seed into the selected generator.
led  output  WIDTH  registered pattern output.
step_tick  output  1  one-cycle pulse, aligned with a led update caused by a step.
wrap  output  1  one-cycle pulse, aligned with step_tick when the step returned the generator to its start state.
step_count  output  16  steps since last reset, mode change or seed_load; saturates at 16'hFFFF.

Behaviour:
- Single clock domain. No gated or derived clocks. Generators advance only on an internal step enable.
- Reset (rst=1 at edge): ring_q=1, johnson_q=0, lfsr_q=1, lfsr_start=1, mode_q=00, div_cnt=0, led=0, step_tick=0, wrap=0, step_count=0. Reset overrides all other inputs.
- Mode change (mode!=mode_q): mode_q<=mode, div_cnt<=0, step_count<=0, no step that cycle. Generator states are retained, so a re-selected generator resumes where it left off.
- Divider: active when run=1 and mode_q!=00. div_cnt increments each cycle. When div_cnt==step_div, step=1 and div_cnt<=0. step_div=0 gives a step every cycle. When run=0 or mode_q=00, div_cnt<=0.
- Single step: run=0 and single_step=1 gives step=1 that cycle (level, not edge). single_step is ignored when run=1.
- Priority per cycle: rst > mode change > seed_load > step.
- seed_load (mode_q!=00) acts on the selected generator only:
  - Ring: loads seed, or 1 if seed==0.
  - Johnson: loads seed.
  - LFSR: loads seed, or 1 if seed==0; lfsr_start<=loaded value.
  - Also clears div_cnt and step_count. No step that cycle.
- A step advances only the generator selected by mode_q:
  - Ring: q<={q[W-2:0],q[W-1]}. Wrap when pre-step q==1<<(W-1).
  - Johnson: q<={q[W-2:0],~q[W-1]}; period 2W from 0. Wrap when next q==0.
  - LFSR (Galois, right shift): q<=(q>>1)^(q[0]?LFSR_TAPS:0). Never 0. Wrap when next q==lfsr_start.
- led is registered and is 0 when mode_q=00 (value after this edge). Otherwise it equals the selected generator state after this edge, so it changes on the same edge as the generator, with no added latency.
- step_tick and wrap are registered and asserted for the cycle after the stepping edge, alongside the new led. step_count increments on each step and saturates at 16'hFFFF.
- mode=00: no steps, seed_load ignored, led=0, states held.

Test Plan:
Bench uses WIDTH=8, LFSR_TAPS=8'hB8.
1. Reset; mode=01, run=1, step_div=0 -> first cycle led=01 (mode change, no step), then 02,04,…,80,01. wrap is high only with the 01 following 80. step_count=8 at that point.
2. mode=10, step_div=3 -> led changes every 4 cycles: 01,03,07,0F,1F,3F,7F,FF,FE,FC,…,80,00. wrap is high exactly on the 16th step (00).
3. mode=11, seed_load with seed=00 -> led=01. Then 255 steps at step_div=0 -> 00 never appears, led returns to 01 on step 255 with a single wrap. With seed=5A, wrap asserts when led returns to 5A.
4. Ring, run=0: three 1-cycle single_step pulses -> exactly 3 steps (01→08). single_step held 5 cycles -> 5 steps. Set run=1 with single_step=1 -> steps only at the divider rate.
5. Ring at led=08, switch mode to 10 then back to 01 -> no step on either switch cycle, step_count=0, led shows the Johnson state then 08 again, and ring resumes 10,20.
6. rst pulsed for one cycle mid-run in LFSR mode -> next cycle led=00, step_tick=0, step_count=0. With mode=11 held, led=01 the following cycle and the sequence restarts from 01.
